reply_cnt: RTL and testbench
============================

REPLY_CNT -- requirements
Module: reply_cnt

Interface
REQ-001 SHALL have parameter START_VALUE, default 8'h00: value of the first transmitted byte.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port activate, input, 1, level; high enables the block, low forces idle.
REQ-005 SHALL have port done, output, 1, high when the sequence is complete.
REQ-006 SHALL have port rx_ready, input, 1, UART receiver byte-valid level.
REQ-007 SHALL have port rx_data, input, 8, received byte, valid while rx_ready is high.
REQ-008 SHALL have port tx_data, output, 8, byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, one-cycle transmit request.
REQ-010 SHALL have port tx_active, input, 1, transmitter busy.
REQ-011 SHALL have port tx_done, input, 1, one-cycle pulse at the end of each transmitted byte.

Function
REQ-012 SHALL implement states IDLE, WAIT_LEN, SEND, WAIT_TX, FINISH.
REQ-013 SHALL, in IDLE with activate high, enter WAIT_LEN on the next clock and clear the byte index i to 0.
REQ-014 SHALL detect a received byte only on a rising edge of rx_ready (registered previous value); an rx_ready level already high when activate rises SHALL be ignored.
REQ-015 SHALL, in WAIT_LEN on an rx_ready rising edge, latch N = rx_data; N = 0 goes to FINISH, otherwise to SEND.
REQ-016 SHALL, in SEND with tx_active low, drive tx_data = START_VALUE + i (mod 256), pulse tx_start for exactly one cycle, and enter WAIT_TX.
REQ-017 SHALL hold in SEND while tx_active is high.
REQ-018 SHALL hold tx_data stable from the tx_start cycle until tx_done.
REQ-019 SHALL, in WAIT_TX on tx_done, increment i (8-bit); if i + 1 = N go to FINISH, otherwise go to SEND.
REQ-020 SHALL ignore rx_ready edges in SEND, WAIT_TX and FINISH.
REQ-021 SHALL assert done in FINISH and hold it until activate goes low.
REQ-022 SHALL, whenever activate is low, go to IDLE on the next clock with done = 0 and tx_start = 0, including mid-transfer.
REQ-023 SHALL treat N = 255 as 255 bytes, with values wrapping modulo 256 from START_VALUE.
REQ-024 SHALL keep tx_start low in every state except the single issue cycle.

Reset
REQ-025 SHALL, while reset is low, asynchronously force IDLE, i = 0, N = 0, done = 0, tx_start = 0, tx_data = 8'h00, and the rx_ready edge register to 1.
REQ-026 SHALL, after reset releases with activate high, begin again at WAIT_LEN with no byte in progress.

Configuration
REQ-027 SHALL, with REPLY_CNT_CHECKSUM_EN defined, send one extra byte before FINISH: the XOR of all sequence bytes (8'h00 when N = 0), using the same SEND/WAIT_TX handshake.
REQ-028 SHALL, without REPLY_CNT_CHECKSUM_EN, send only the N sequence bytes and contain no checksum logic.

Verification
REQ-029 SHALL cover: activate, rx byte 8'h03 -> tx bytes 00, 01, 02 with one tx_start each, then done = 1; with the macro defined, a fourth byte 03.
REQ-030 SHALL cover: rx byte 8'h00 -> no tx_start, done = 1 within 2 cycles; with the macro defined, a single byte 00.
REQ-031 SHALL cover: rx_ready already high with 8'h72 at activate -> no length latched; a later rising edge with 8'h02 -> bytes 00, 01.
REQ-032 SHALL cover: START_VALUE = 8'hFE, N = 3 -> bytes FE, FF, 00.
REQ-033 SHALL cover: activate dropped after the first tx_done of N = 5 -> IDLE next cycle, done = 0, no further tx_start.
REQ-034 SHALL cover: reset low during WAIT_TX -> outputs at reset values immediately; after release with activate high, a new length byte is required.

Source files
------------

// File: rtl/reply_cnt.sv
// Replies to a received length byte N with N counting bytes from START_VALUE.
// Define REPLY_CNT_CHECKSUM_EN to append the XOR of all sent sequence bytes.
module reply_cnt #(
    parameter logic [7:0] START_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    output logic       done,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_active,
    input  logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LEN,
        SEND,
        WAIT_TX,
        FINISH
    } state_t;

    state_t     state, state_d;
    logic [7:0] idx, idx_d;
    logic [7:0] len, len_d;
    logic [7:0] tx_data_d;
    logic       tx_start_d;
    logic       rx_prev;
    logic       rx_rise;
    logic [7:0] idx_inc;
    logic [7:0] seq_byte;
`ifdef REPLY_CNT_CHECKSUM_EN
    logic [7:0] csum, csum_d;
    logic       csum_phase, csum_phase_d;
`endif

    // rx_prev resets high so a level already present is never taken as a new byte
    assign rx_rise  = rx_ready & ~rx_prev;
    assign idx_inc  = idx + 8'd1;
    assign seq_byte = START_VALUE + idx;
    assign done     = (state == FINISH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 8'h00;
            len      <= 8'h00;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            rx_prev  <= 1'b1;
`ifdef REPLY_CNT_CHECKSUM_EN
            csum       <= 8'h00;
            csum_phase <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            len      <= len_d;
            tx_data  <= tx_data_d;
            tx_start <= tx_start_d;
            rx_prev  <= rx_ready;
`ifdef REPLY_CNT_CHECKSUM_EN
            csum       <= csum_d;
            csum_phase <= csum_phase_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        len_d      = len;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
`ifdef REPLY_CNT_CHECKSUM_EN
        csum_d       = csum;
        csum_phase_d = csum_phase;
`endif
        if (!activate) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_d = WAIT_LEN;
                    idx_d   = 8'h00;
`ifdef REPLY_CNT_CHECKSUM_EN
                    csum_d       = 8'h00;
                    csum_phase_d = 1'b0;
`endif
                end
                WAIT_LEN: begin
                    if (rx_rise) begin
                        len_d = rx_data;
                        if (rx_data == 8'h00) begin
`ifdef REPLY_CNT_CHECKSUM_EN
                            csum_phase_d = 1'b1;
                            state_d      = SEND;
`else
                            state_d = FINISH;
`endif
                        end else begin
                            state_d = SEND;
                        end
                    end
                end
                SEND: begin
                    // tx_data is only loaded here, so it holds through WAIT_TX
                    if (!tx_active) begin
                        tx_start_d = 1'b1;
                        state_d    = WAIT_TX;
`ifdef REPLY_CNT_CHECKSUM_EN
                        if (csum_phase) begin
                            tx_data_d = csum;
                        end else begin
                            tx_data_d = seq_byte;
                            csum_d    = csum ^ seq_byte;
                        end
`else
                        tx_data_d = seq_byte;
`endif
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        state_d = SEND;
`ifdef REPLY_CNT_CHECKSUM_EN
                        if (csum_phase) begin
                            state_d = FINISH;
                        end else begin
                            idx_d = idx_inc;
                            if (idx_inc == len) csum_phase_d = 1'b1;
                        end
`else
                        idx_d = idx_inc;
                        if (idx_inc == len) state_d = FINISH;
`endif
                    end
                end
                FINISH: begin
                    state_d = FINISH;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reply_cnt.sv
// Scoreboard bench for reply_cnt: two instances (START_VALUE 00 and FE) share stimulus
// and a randomized transmitter responder; expected bytes come from a list model.
module tb_reply_cnt;

    logic       clk;
    logic       reset;
    logic       activate;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_active;
    logic       tx_done;
    logic       done0, done1;
    logic       tx_start0, tx_start1;
    logic [7:0] tx_data0, tx_data1;

    int n_checks = 0;
    int n_err    = 0;
    int starts0  = 0;
    int done_cnt = 0;
    int busy     = 0;
    int tail     = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] cur0 = 8'h00;
    logic [7:0] cur1 = 8'h00;

    reply_cnt #(.START_VALUE(8'h00)) dut0 (
        .clk(clk), .reset(reset), .activate(activate), .done(done0),
        .rx_ready(rx_ready), .rx_data(rx_data), .tx_data(tx_data0),
        .tx_start(tx_start0), .tx_active(tx_active), .tx_done(tx_done)
    );

    reply_cnt #(.START_VALUE(8'hFE)) dut1 (
        .clk(clk), .reset(reset), .activate(activate), .done(done1),
        .rx_ready(rx_ready), .rx_data(rx_data), .tx_data(tx_data1),
        .tx_start(tx_start1), .tx_active(tx_active), .tx_done(tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: reply to length n is the list start+k (k < n) mod 256, then optionally its XOR.
    task automatic push_exp(input int n);
        logic [7:0] x0, x1, kk;
        x0 = 8'h00;
        x1 = 8'h00;
        for (int k = 0; k < n; k++) begin
            kk = k[7:0];
            q0.push_back(kk);
            x0 = x0 ^ kk;
            q1.push_back(8'hFE + kk);
            x1 = x1 ^ (8'hFE + kk);
        end
`ifdef REPLY_CNT_CHECKSUM_EN
        q0.push_back(x0);
        q1.push_back(x1);
`endif
    endtask

    task automatic send_len(input logic [7:0] v);
        rx_ready = 1'b0;
        cyc(1);
        rx_data  = v;
        rx_ready = 1'b1;
        cyc(2);
        rx_ready = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit noise);
        int k;
        k = 0;
        while (done0 !== 1'b1 && k < max) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                rx_ready = ~rx_ready;
                rx_data  = 8'($urandom);
            end
            cyc(1);
            k++;
        end
        chk("done0", done0, 1);
        chk("done1", done1, 1);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        rx_ready = 1'b0;
    endtask

    task automatic end_txn();
        activate = 1'b0;
        cyc(1);
        chk("done_clear0", done0, 0);
        chk("done_clear1", done1, 0);
    endtask

    // Monitor: every issued byte must match the head of the scoreboard queue
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (tx_start0) begin
                starts0++;
                if (q0.size() == 0) chk("unexpected_tx_start0", tx_start0, 0);
                else begin
                    cur0 = q0.pop_front();
                    chk("tx_byte0", tx_data0, cur0);
                end
            end
            if (tx_start1) begin
                if (q1.size() == 0) chk("unexpected_tx_start1", tx_start1, 0);
                else begin
                    cur1 = q1.pop_front();
                    chk("tx_byte1", tx_data1, cur1);
                end
            end
        end
    end

    // Transmitter model: random busy time, tx_done pulse, optional busy tail afterwards
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (reset !== 1'b1 || activate !== 1'b1) begin
                busy      = 0;
                tail      = 0;
                tx_active = 1'b0;
            end else if (tx_start0) begin
                chk("start_while_busy", tx_active, 0);
                tx_active = 1'b1;
                busy      = $urandom_range(1, 4);
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    tx_done = 1'b1;
                    done_cnt++;
                    chk("tx_hold0", tx_data0, cur0);
                    chk("tx_hold1", tx_data1, cur1);
                    tail = $urandom_range(0, 2);
                    if (tail == 0) tx_active = 1'b0;
                end
            end else if (tail > 0) begin
                tail--;
                if (tail == 0) tx_active = 1'b0;
            end
        end
    end

    initial begin
        int s, d, k, n;
        reset    = 1'b0;
        activate = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        cyc(3);
        chk("rst_done", done0, 0);
        chk("rst_tx_start", tx_start0, 0);
        chk("rst_tx_data0", tx_data0, 0);
        chk("rst_tx_data1", tx_data1, 0);
        reset = 1'b1;
        cyc(2);

        // length 3
        activate = 1'b1;
        cyc(1);
        push_exp(3);
        send_len(8'h03);
        wait_done(100, 1'b0);
        end_txn();

        // length 0
        activate = 1'b1;
        cyc(1);
        s = starts0;
        push_exp(0);
        cyc(1);
        rx_data  = 8'h00;
        rx_ready = 1'b1;
`ifdef REPLY_CNT_CHECKSUM_EN
        wait_done(60, 1'b0);
`else
        cyc(2);
        chk("len0_done", done0, 1);
        chk("len0_no_start", starts0 - s, 0);
`endif
        rx_ready = 1'b0;
        end_txn();

        // rx_ready already high at activate must not count as a length byte
        rx_data  = 8'h72;
        rx_ready = 1'b1;
        cyc(2);
        activate = 1'b1;
        s = starts0;
        cyc(6);
        chk("stale_level_done", done0, 0);
        chk("stale_level_no_start", starts0 - s, 0);
        push_exp(2);
        send_len(8'h02);
        wait_done(100, 1'b0);
        end_txn();

        // drop activate after the first tx_done of a 5-byte reply
        activate = 1'b1;
        cyc(1);
        push_exp(5);
        d = done_cnt;
        send_len(8'h05);
        k = 0;
        while (done_cnt == d && k < 100) begin
            cyc(1);
            k++;
        end
        chk("abort_first_tx_done", done_cnt - d, 1);
        activate = 1'b0;
        q0.delete();
        q1.delete();
        s = starts0;
        cyc(1);
        chk("abort_done", done0, 0);
        chk("abort_tx_start", tx_start0, 0);
        cyc(10);
        chk("abort_no_more_starts", starts0 - s, 0);

        // asynchronous reset while the second byte is in WAIT_TX
        activate = 1'b1;
        cyc(1);
        push_exp(4);
        s = starts0;
        send_len(8'h04);
        k = 0;
        while (starts0 < s + 2 && k < 100) begin
            cyc(1);
            k++;
        end
        chk("reset_case_second_start", starts0 - s, 2);
        reset = 1'b0;
        #1;
        chk("arst_done", done0, 0);
        chk("arst_tx_start", tx_start0, 0);
        chk("arst_tx_data0", tx_data0, 0);
        chk("arst_tx_data1", tx_data1, 0);
        q0.delete();
        q1.delete();
        cyc(2);
        reset = 1'b1;
        s = starts0;
        cyc(5);
        chk("post_reset_idle_done", done0, 0);
        chk("post_reset_no_start", starts0 - s, 0);
        push_exp(2);
        send_len(8'h02);
        wait_done(100, 1'b0);
        end_txn();

        // randomized lengths, including the full 255-byte reply
        for (int t = 0; t < 10; t++) begin
            n = (t == 5) ? 255 : $urandom_range(1, 12);
            activate = 1'b1;
            cyc($urandom_range(1, 3));
            push_exp(n);
            send_len(n[7:0]);
            wait_done(n * 12 + 60, 1'b1);
            end_txn();
            cyc($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
